// File: rtl/gpu_command_decoder.sv
// GPU command decoder: turns a stream of set/draw commands into held draw packets.
// Shadow registers collect coordinates and radius; draw opcodes snapshot them into a packet.
module gpu_command_decoder #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned PARAM_BITS   = 25
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [3:0]              opcode_i,
  input  logic [PARAM_BITS-1:0]   parameters_i,
  output logic                    draw_valid_o,
  input  logic                    draw_ready_i,
  output logic [1:0]              shape_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    illegal_o,
  output logic                    busy_o
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  localparam logic [3:0] OP_CLEAR  = 4'd0;
  localparam logic [3:0] OP_SET_P1 = 4'd1;
  localparam logic [3:0] OP_SET_P2 = 4'd2;
  localparam logic [3:0] OP_SET_R  = 4'd3;
  localparam logic [3:0] OP_LINE   = 4'd4;
  localparam logic [3:0] OP_CIRCLE = 4'd6;

  state_t                  r_state;
  logic [WIDTH_BITS-1:0]   r_sx1, r_sx2, r_srad;
  logic [HEIGHT_BITS-1:0]  r_sy1, r_sy2;
  logic                    r_valid, r_busy, r_illegal;
  logic [1:0]              r_shape;
  logic [WIDTH_BITS-1:0]   r_x1, r_x2, r_rad;
  logic [HEIGHT_BITS-1:0]  r_y1, r_y2;
  logic [CHANNEL_BITS-1:0] r_r, r_g, r_b;

  logic                    w_accept, w_is_draw, w_is_illegal;
  logic [WIDTH_BITS-1:0]   w_x;
  logic [HEIGHT_BITS-1:0]  w_y;
  logic [CHANNEL_BITS-1:0] w_r, w_g, w_b;
  logic                    w_unused_params;

  // Payload field extraction; bits above the widest field are ignored.
  assign w_x = parameters_i[WIDTH_BITS-1:0];
  assign w_y = parameters_i[WIDTH_BITS +: HEIGHT_BITS];
  assign w_b = parameters_i[CHANNEL_BITS-1:0];
  assign w_g = parameters_i[CHANNEL_BITS +: CHANNEL_BITS];
  assign w_r = parameters_i[2*CHANNEL_BITS +: CHANNEL_BITS];
  assign w_unused_params = ^parameters_i;

  assign cmd_ready_o  = (r_state == ST_IDLE) || draw_ready_i;
  assign w_accept     = cmd_valid_i && cmd_ready_o;
  assign w_is_draw    = (opcode_i >= OP_LINE) && (opcode_i <= OP_CIRCLE);
  assign w_is_illegal = opcode_i > OP_CIRCLE;

  // Handshake FSM, shadow registers and packet registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_sx1     <= '0;
      r_sx2     <= '0;
      r_sy1     <= '0;
      r_sy2     <= '0;
      r_srad    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_shape   <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_y1      <= '0;
      r_y2      <= '0;
      r_rad     <= '0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else begin
      r_illegal <= w_accept && w_is_illegal;

      if (w_accept) begin
        case (opcode_i)
          OP_CLEAR: begin
            r_sx1  <= '0;
            r_sx2  <= '0;
            r_sy1  <= '0;
            r_sy2  <= '0;
            r_srad <= '0;
          end
          OP_SET_P1: begin
            r_sx1 <= w_x;
            r_sy1 <= w_y;
          end
          OP_SET_P2: begin
            r_sx2 <= w_x;
            r_sy2 <= w_y;
          end
          OP_SET_R: r_srad <= w_x;
          default: ;
        endcase
      end

      // Opcodes 4/5/6 map onto shapes 0/1/2 through their low two bits.
      if (w_accept && w_is_draw) begin
        r_shape <= opcode_i[1:0];
        r_x1    <= r_sx1;
        r_x2    <= r_sx2;
        r_y1    <= r_sy1;
        r_y2    <= r_sy2;
        r_rad   <= r_srad;
        r_r     <= w_r;
        r_g     <= w_g;
        r_b     <= w_b;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_draw) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (draw_ready_i && !(w_accept && w_is_draw)) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign draw_valid_o = r_valid;
  assign busy_o       = r_busy;
  assign illegal_o    = r_illegal;
  assign shape_o      = r_shape;
  assign x1_o         = r_x1;
  assign x2_o         = r_x2;
  assign y1_o         = r_y1;
  assign y2_o         = r_y2;
  assign rad_o        = r_rad;
  assign r_o          = r_r;
  assign g_o          = r_g;
  assign b_o          = r_b;

endmodule

// File: doc/gpu_command_decoder.md
GPU_COMMAND_DECODER -- requirements
Module: gpu_command_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH_BITS, default 10, x/radius coordinate width.
REQ-002 The block SHALL have parameter HEIGHT_BITS, default 9, y coordinate width.
REQ-003 The block SHALL have parameter CHANNEL_BITS, default 8, per-colour-channel width.
REQ-004 The block SHALL have parameter PARAM_BITS, default 25, command parameter width; legal only if PARAM_BITS >= WIDTH_BITS+HEIGHT_BITS and PARAM_BITS >= 3*CHANNEL_BITS.
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset; one clock, synchronous and active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i.
- opcode_i  in  4  command opcode.
- parameters_i  in  PARAM_BITS  command payload.
- draw_valid_o  out  1  draw packet valid.
- draw_ready_i  in  1  downstream accepts packet.
- shape_o  out  2  0 line, 1 rect, 2 circle, 3 reserved.
- x1_o, x2_o  out  WIDTH_BITS  packet endpoints x.
- y1_o, y2_o  out  HEIGHT_BITS  packet endpoints y.
- rad_o  out  WIDTH_BITS  packet radius.
- r_o, g_o, b_o  out  CHANNEL_BITS  packet colour.
- illegal_o  out  1  one-cycle pulse on illegal opcode.
- busy_o  out  1  high in state HOLD.

Function
REQ-006 A command SHALL be accepted only on a cycle with cmd_valid_i and cmd_ready_o both high; cmd_ready_o = (state==IDLE) or draw_ready_i.
REQ-007 Internal shadow registers SHALL hold x1, y1, x2, y2 (set by commands) and rad; all outputs are registered.
REQ-008 Opcode 0 (clear) SHALL zero all shadow registers; the pending packet is unaffected.
REQ-009 Opcode 1/2 SHALL load x1/x2 from parameters_i[WIDTH_BITS-1:0] and y1/y2 from parameters_i[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS].
REQ-010 Opcode 3 SHALL load rad from parameters_i[WIDTH_BITS-1:0].
REQ-011 Opcodes 4/5/6 (line/rect/circle) SHALL form a packet: shape 0/1/2, current shadow coordinates and radius, b=parameters_i[CHANNEL_BITS-1:0], g=[2*CHANNEL_BITS-1:CHANNEL_BITS], r=[3*CHANNEL_BITS-1:2*CHANNEL_BITS].
REQ-012 A set command accepted in the same cycle as a draw is impossible (one command per cycle); a set followed by draw on the next cycle SHALL use the new value.
REQ-013 Opcodes 7-15 SHALL be accepted, change no register, and pulse illegal_o the following cycle.
REQ-014 FSM IDLE: draw accepted -> HOLD, packet on outputs and draw_valid_o high next cycle (latency 1).
REQ-015 FSM HOLD: draw_valid_o held with outputs stable until draw_ready_i; on handshake with no new draw accepted -> IDLE, draw_valid_o low next cycle; with a new draw accepted the same cycle -> stay HOLD, new packet next cycle (no bubble).
REQ-016 In HOLD without draw_ready_i, cmd_ready_o SHALL be low, so no commands, including set commands, are accepted.
REQ-017 Upper unused parameter bits SHALL be ignored; no arithmetic or saturation is performed.

Reset
REQ-018 While rst_i is high at a clock edge: state IDLE, all shadow registers and packet outputs 0, draw_valid_o, illegal_o, busy_o 0; a pending packet is discarded.
REQ-019 cmd_ready_o SHALL be high in the first cycle after reset releases.

Verification
REQ-020 Defaults; opcode 1 param 0x0C05, opcode 2 param 0x1414, opcode 4 param 0xFF8040 -> next cycle draw_valid_o=1, shape 0, x1=5 y1=3 x2=20 y2=5, r=0xFF g=0x80 b=0x40.
REQ-021 Draw issued, draw_ready_i low 5 cycles -> outputs stable, cmd_ready_o=0, busy_o=1; draw_ready_i high with opcode 5 valid -> rect packet next cycle, draw_valid_o never drops.
REQ-022 Opcode 3 param 0x3FF then opcode 6 -> rad_o=1023, shape 2; opcode 0 then opcode 6 -> rad_o=0, x1=y1=0.
REQ-023 Opcode 9 accepted -> illegal_o high exactly one cycle, shadow registers unchanged, draw_valid_o stays 0.
REQ-024 rst_i asserted while in HOLD -> next cycle draw_valid_o=0, all outputs 0, cmd_ready_o=1.
REQ-025 Parametrised run WIDTH_BITS=12, HEIGHT_BITS=11, CHANNEL_BITS=5, PARAM_BITS=23: opcode 1 param (7<<12)|4095 -> x1=4095, y1=7.
